// File: rtl/sound_out_stage.sv
// sound_out_stage: one-pole IIR low-pass, fractional-tick decimation, master gain/mute with saturation, valid/ready output.
// Define SOUND_OUT_MUTE_RAMP_EN to step eff_gain by +/-1 per tick toward its target instead of loading it.
module sound_out_stage #(
  parameter int OUT_RATE   = 48000,
  parameter int FILT_SHIFT = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [27:0] clock_rate,
  input  logic [15:0] sample_l_in,
  input  logic [15:0] sample_r_in,
  input  logic [7:0]  gain,
  input  logic        mute,
  input  logic        clip_clr,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        clip,
  output logic [7:0]  overrun_cnt
);
  localparam int AW = 17 + FILT_SHIFT;

  logic [27:0] clk_rate_q, sum_q, sum_d;
  logic [28:0] s;
  logic tick, load, v1_q, out_valid_q, clip_q;
  logic signed [AW-1:0] acc_l_q, acc_r_q, acc_l_d, acc_r_d;
  logic signed [15:0] y_l, y_r, y_l_q, y_r_q;
  logic [7:0] tgt, eff_gain_q, eff_gain_d, g_q, overrun_q;
  logic signed [24:0] p_l, p_r;
  logic [16:0] sat_l, sat_r;
  logic [15:0] out_l_q, out_r_q;

  // Returns {saturated, value} for p >>> 7 clamped to 16-bit signed.
  function automatic logic [16:0] sat16(input logic signed [24:0] p);
    logic signed [24:0] q;
    q = p >>> 7;
    return (q > 25'sd32767) ? {1'b1, 16'h7fff} :
           (q < -25'sd32768) ? {1'b1, 16'h8000} : {1'b0, q[15:0]};
  endfunction

  always_comb begin
    s = {1'b0, sum_q} + 29'(OUT_RATE);
    tick = (clk_rate_q != '0) && (s >= {1'b0, clk_rate_q});
    sum_d = (clk_rate_q == '0) ? '0 : tick ? 28'(s - {1'b0, clk_rate_q}) : s[27:0];
    acc_l_d = acc_l_q + AW'($signed(sample_l_in)) - (acc_l_q >>> FILT_SHIFT);
    acc_r_d = acc_r_q + AW'($signed(sample_r_in)) - (acc_r_q >>> FILT_SHIFT);
    y_l = 16'(acc_l_q >>> FILT_SHIFT);
    y_r = 16'(acc_r_q >>> FILT_SHIFT);
    tgt = mute ? 8'd0 : gain;
`ifdef SOUND_OUT_MUTE_RAMP_EN
    eff_gain_d = !tick ? eff_gain_q :
                 (eff_gain_q < tgt) ? eff_gain_q + 8'd1 :
                 (eff_gain_q > tgt) ? eff_gain_q - 8'd1 : eff_gain_q;
`else
    eff_gain_d = tick ? tgt : eff_gain_q;
`endif
    p_l = 25'(y_l_q) * 25'($signed({1'b0, g_q}));
    p_r = 25'(y_r_q) * 25'($signed({1'b0, g_q}));
    sat_l = sat16(p_l);
    sat_r = sat16(p_r);
    load = v1_q && (!out_valid_q || out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_rate_q  <= '0;
      sum_q       <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      eff_gain_q  <= '0;
      g_q         <= '0;
      y_l_q       <= '0;
      y_r_q       <= '0;
      v1_q        <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= '0;
    end else begin
      clk_rate_q <= clock_rate;
      sum_q      <= sum_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      eff_gain_q <= eff_gain_d;
      v1_q       <= tick;
      // Capture the filter output and the gain as updated by this tick.
      if (tick) begin
        y_l_q <= y_l;
        y_r_q <= y_r;
        g_q   <= eff_gain_d;
      end
      if (load) begin
        out_l_q <= sat_l[15:0];
        out_r_q <= sat_r[15:0];
      end
      out_valid_q <= load || (out_valid_q && !out_ready);
      clip_q      <= (v1_q && (sat_l[16] || sat_r[16])) || (clip_q && !clip_clr);
      if (v1_q && !load && overrun_q != 8'hff) overrun_q <= overrun_q + 8'd1;
    end
  end

  assign out_l       = out_l_q;
  assign out_r       = out_r_q;
  assign out_valid   = out_valid_q;
  assign clip        = clip_q;
  assign overrun_cnt = overrun_q;
endmodule

// File: tb/tb_sound_out_stage.sv
// tb_sound_out_stage: randomized bench for sound_out_stage against a cycle-level arithmetic reference model.
module tb_sound_out_stage;
  localparam int OUT_RATE = 48000;
  localparam int FS = 6;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [27:0] clock_rate = '0;
  logic [15:0] sample_l_in = '0, sample_r_in = '0;
  logic [7:0]  gain = '0;
  logic        mute = 1'b0, clip_clr = 1'b0, out_ready = 1'b0;
  logic [15:0] out_l, out_r;
  logic        out_valid, clip;
  logic [7:0]  overrun_cnt;

  int n_run = 0, n_fail = 0, frames = 0;
  longint m_sum, m_rate, m_acc_l, m_acc_r, m_gain, m_l, m_r, m_ovr, p_l, p_r;
  bit m_v, m_clip, p_v, p_sat;

  sound_out_stage #(.OUT_RATE(OUT_RATE), .FILT_SHIFT(FS)) dut (
    .clk(clk), .rst_n(rst_n), .clock_rate(clock_rate),
    .sample_l_in(sample_l_in), .sample_r_in(sample_r_in),
    .gain(gain), .mute(mute), .clip_clr(clip_clr),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .out_ready(out_ready),
    .clip(clip), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, longint got, longint exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat16(longint v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction

  function automatic bit near(logic [15:0] v, longint e);
    longint d = longint'($signed(v)) - e;
    return d >= -1 && d <= 1;
  endfunction

  task automatic model_reset();
    m_sum = 0; m_rate = 0; m_acc_l = 0; m_acc_r = 0; m_gain = 0;
    m_l = 0; m_r = 0; m_ovr = 0; m_v = 0; m_clip = 0;
    p_v = 0; p_l = 0; p_r = 0; p_sat = 0;
  endtask

  // One clock edge of the reference: inputs are those present before the edge.
  task automatic model_edge();
    longint tgt, vl, vr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (p_v && (!m_v || out_ready)) begin
      m_l = p_l; m_r = p_r; m_v = 1;
    end else if (p_v) m_ovr = m_ovr < 255 ? m_ovr + 1 : 255;
    else if (out_ready) m_v = 0;
    m_clip = (p_v && p_sat) || (m_clip && !clip_clr);
    p_v = 0;
    if (m_rate != 0 && m_sum + OUT_RATE >= m_rate) begin
      m_sum = m_sum + OUT_RATE - m_rate;
      tgt = mute ? 0 : gain;
`ifdef SOUND_OUT_MUTE_RAMP_EN
      if (m_gain < tgt) m_gain++;
      else if (m_gain > tgt) m_gain--;
`else
      m_gain = tgt;
`endif
      vl = ((m_acc_l >>> FS) * m_gain) >>> 7;
      vr = ((m_acc_r >>> FS) * m_gain) >>> 7;
      p_l = sat16(vl); p_r = sat16(vr);
      p_sat = (p_l != vl) || (p_r != vr);
      p_v = 1;
    end else m_sum = m_rate == 0 ? 0 : m_sum + OUT_RATE;
    m_acc_l = m_acc_l + longint'($signed(sample_l_in)) - (m_acc_l >>> FS);
    m_acc_r = m_acc_r + longint'($signed(sample_r_in)) - (m_acc_r >>> FS);
    m_rate = clock_rate;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("out_valid", out_valid, m_v);
    check("out_l", $signed(out_l), m_l);
    check("out_r", $signed(out_r), m_r);
    check("clip", clip, m_clip);
    check("overrun_cnt", overrun_cnt, m_ovr);
    if (out_valid && out_ready) frames++;
  endtask

  task automatic run(int n, bit rnd);
    repeat (n) begin
      if (rnd) begin
        sample_l_in = 16'($urandom);
        sample_r_in = 16'($urandom);
      end
      step();
    end
  endtask

  task automatic wait_valid(string tag);
    int k = 0;
    do begin
      step();
      k++;
    end while (!out_valid && k < 50);
    check(tag, out_valid, 1);
  endtask

  initial begin
    model_reset();
    run(3, 1);
    check("rst_valid", out_valid, 0);
    check("rst_out_l", out_l, 0);
    check("rst_ovr", overrun_cnt, 0);

    clock_rate = 28'd480000; gain = 8'h80; out_ready = 1'b1; rst_n = 1'b1;
    run(20, 1);
    frames = 0;
    run(1000, 1);
    check("frames_1000", frames, 100);
    check("ovr_zero", overrun_cnt, 0);

    sample_l_in = 16'h1000; sample_r_in = 16'h1000;
    run(3000, 0);
    check("dc_l_unity", near(out_l, 'h1000), 1);
    check("dc_r_unity", near(out_r, 'h1000), 1);
    gain = 8'h40;
    run(3000, 0);
    check("dc_l_half", near(out_l, 'h800), 1);

    gain = 8'hff; sample_l_in = 16'h7000; sample_r_in = 16'h7000;
    run(3000, 0);
    check("sat_hi", $signed(out_l), 32767);
    check("clip_set", clip, 1);
    sample_l_in = 16'h9000; sample_r_in = 16'h9000;
    run(3000, 0);
    check("sat_lo", $signed(out_r), -32768);
    clip_clr = 1'b1; step(); clip_clr = 1'b0;
    run(30, 0);
    check("clip_resets", clip, 1);
    sample_l_in = 16'h0; sample_r_in = 16'h0;
    run(3000, 0);
    clip_clr = 1'b1; step(); clip_clr = 1'b0;
    run(30, 0);
    check("clip_clr", clip, 0);

    wait_valid("bp_sync");
    out_ready = 1'b0;
    run(45, 1);
    check("bp_ovr4", overrun_cnt, 4);
    out_ready = 1'b1;
    run(30, 1);
    check("bp_resume", overrun_cnt, 4);
    out_ready = 1'b0;
    run(3100, 1);
    check("bp_ovr_sat", overrun_cnt, 255);
    out_ready = 1'b1;
    run(30, 1);

    repeat (2000) begin
      out_ready = 1'($urandom);
      gain = 8'($urandom);
      mute = ($urandom_range(0, 7) == 0);
      clip_clr = ($urandom_range(0, 15) == 0);
      run(1, 1);
    end
    clip_clr = 1'b0; mute = 1'b0; out_ready = 1'b1;

    gain = 8'h80; sample_l_in = 16'h1000; sample_r_in = 16'h1000;
    run(3000, 0);
    wait_valid("mute_sync");
    mute = 1'b1;
    wait_valid("mute_wait");
`ifdef SOUND_OUT_MUTE_RAMP_EN
    check("mute_first", $signed(out_l), 'h1000 - 'h20);
`else
    check("mute_first", $signed(out_l), 0);
`endif
    run(1400, 0);
    check("mute_final", $signed(out_l), 0);
    mute = 1'b0;

    begin
      int k = 0;
      do begin
        run(1, 1);
        k++;
      end while (!p_v && k < 50);
      check("pipe_busy", p_v, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_out_l", out_l, 0);
    check("mid_rst_clip", clip, 0);
    check("mid_rst_ovr", overrun_cnt, 0);
    model_reset();
    run(3, 1);
    rst_n = 1'b1;
    run(200, 1);

    clock_rate = '0;
    run(5, 1);
    frames = 0;
    run(10000, 1);
    check("zero_rate", frames, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/sound_out_stage.md
# sound_out_stage

Output conditioning stage downstream of the sound mixer. It takes the mixed 16-bit signed left/right samples, which are valid on every `clk`, and low-pass filters them with a one-pole IIR. It then decimates to a fixed output rate using a fractional tick generator, applies master gain/mute with saturation, and presents frames on a valid/ready interface to the audio output path.

## Interface
- `OUT_RATE`, default 48000: output sample rate in Hz.
- `FILT_SHIFT`, default 6: IIR coefficient exponent, giving a = 2^-FILT_SHIFT. Legal range 2..10.
- `clk` input, 1 bit: system clock, the same clock as the mixer.
- `rst_n` input, 1 bit: asynchronous active-low reset. Every register clears on assertion; release is synchronous to `clk`.
- `clock_rate` input, 28 bits: `clk` frequency in Hz. Quasi-static; registered internally.
- `sample_l_in`, `sample_r_in` input, 16 bits: signed mixed samples, sampled every cycle.
- `gain` input, 8 bits: unsigned master gain. 0x80 = unity; 0xFF ≈ 1.99.
- `mute` input, 1 bit: forces target gain to 0.
- `clip_clr` input, 1 bit: clears `clip` (single-cycle pulse).
- `out_l`, `out_r` output, 16 bits: signed output frame.
- `out_valid` output, 1 bit: frame available.
- `out_ready` input, 1 bit: consumer accepts the frame when `out_valid && out_ready`.
- `clip` output, 1 bit: sticky saturation flag.
- `overrun_cnt` output, 8 bits: count of dropped frames, saturating at 0xFF.

## Operation
- **clock_rate register:** `clock_rate` is registered into `clk_rate_r` every cycle.
- **IIR filter**, per channel, every cycle:
  - Accumulator `acc` is signed, 17+FILT_SHIFT bits.
  - Update: `acc <= acc + sext(x) - (acc >>> FILT_SHIFT)`.
  - Filter output: `y = acc >>> FILT_SHIFT`, truncated to 16 bits. The form cannot overflow.
- **Tick generator:**
  - 28-bit `sum`. Each cycle, `s = sum + OUT_RATE`.
  - If `s >= clk_rate_r`: `sum <= s - clk_rate_r` and `tick = 1`.
  - Otherwise: `sum <= s`.
  - If `clk_rate_r == 0`: `sum` is held at 0 and no ticks occur.
- **Gain register `eff_gain`** (8 bits), updated on tick. Target = `mute ? 0 : gain`.
- **Gain stage, cycle T+1** after tick cycle T:
  - Compute `p = y * {1'b0, eff_gain}`, 25-bit signed, using `y` and `eff_gain` as captured at tick T.
  - Register `q = p >>> 7`, arithmetic.
- **Saturation, cycle T+2:**
  - `q` saturates to [-32768, 32767].
  - Any saturated channel sets `clip`.
  - If `clip_clr` and a saturation event coincide, the set wins.
- **Output register, cycle T+2:**
  - If `!out_valid || out_ready`: load `out_l`/`out_r` and set `out_valid = 1`.
  - Otherwise: discard the new frame, hold the old frame, and increment `overrun_cnt` (saturating).
- **Handshake:**
  - Transfer occurs when `out_valid && out_ready`.
  - `out_valid` deasserts the cycle after a transfer unless a new frame loads in the same cycle.
  - `out_l`/`out_r` stay stable while `out_valid && !out_ready`.
- **Reset mid-operation:** everything returns to reset values immediately, including in-flight pipeline frames. No frame is emitted from pre-reset data.

## Timing
- Reset values:
  - Outputs: `out_l = 0`, `out_r = 0`, `out_valid = 0`, `clip = 0`, `overrun_cnt = 0`.
  - Internal: `sum = 0`, `acc = 0`, `eff_gain = 0`, `clk_rate_r = 0`, pipeline valid = 0.
- Latency: tick in cycle T gives `out_valid` high in cycle T+2. The gain/saturate pipeline has fixed 2-cycle depth.
- Tick spacing is ⌊clk_rate/OUT_RATE⌋ or that value +1 cycles. The long-run average is exact.
- The first tick after reset occurs no earlier than the cycle after `clk_rate_r` becomes nonzero.
- Frame data reflects the filter state at tick cycle T, i.e. input up to T-1.
- The consumer may hold `out_ready` high permanently; no frame is ever lost in that case.

## Configuration
- **`SOUND_OUT_MUTE_RAMP_EN` defined:** on each tick, `eff_gain` steps by ±1 toward the target and holds when equal. Mute, unmute and gain changes are click-free, taking at most 255 ticks.
- **Not defined:** on each tick, `eff_gain` loads the target directly.
- In both builds, `eff_gain` is 0 at reset. The ramp build therefore fades in from silence after reset.

## Test plan
- **Decimation rate:** `clock_rate`=480000, OUT_RATE=48000, `out_ready`=1 → `out_valid` pulses exactly every 10 cycles; 100 frames in 1000 cycles; `overrun_cnt` = 0.
- **DC gain:** constant input 0x1000 on both channels, `gain`=0x80, run until settled → `out_l` = `out_r` = 0x1000 ±1. With `gain`=0x40 → 0x0800 ±1.
- **Saturation:** constant 0x7000, `gain`=0xFF → `out_l` = 0x7FFF and `clip` = 1. A negative input -0x7000 gives 0x8000. A `clip_clr` pulse with saturation continuing leaves `clip` = 1. With input 0 and `clip_clr` pulsed → `clip` = 0.
- **Backpressure:** hold `out_ready`=0 for 5 ticks → first frame held stable and `overrun_cnt` = 4. Raise `out_ready` → transfer, then new frames resume. Hold `out_ready`=0 for 300 ticks → `overrun_cnt` = 0xFF.
- **Mute:** constant 0x1000, `gain`=0x80, `mute`=1.
  - Without the macro → next frame = 0.
  - With `SOUND_OUT_MUTE_RAMP_EN` → output drops by 0x20 per frame, reaching 0 after 128 frames.
- **Reset and zero rate:** assert `rst_n`=0 while a frame is in the pipeline → all outputs 0 immediately and no post-reset frame until a new tick. With `clock_rate`=0 → no `out_valid` for 10000 cycles.
